// File: rtl/velocity_cell_ctrl.sv
// rtl/velocity_cell_ctrl.sv - streams one cell's velocities from RAM to the motion-update unit and writes results back
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse, begins a pass (ignored unless idle)
//   out_stall         motion-update unit cannot take a velocity next cycle
//   wb_valid/wb_data  updated velocity returned in particle order
//   mem_*             single-port cell RAM (read data one cycle after rden)
//   vel_out(_valid)   velocity to the motion-update unit
//   particle_count    count word latched from address 0 (clamped)
//   busy, done        pass in progress / one-cycle completion pulse
//   wb_overflow       sticky: a write-back arrived when none could be taken
module velocity_cell_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  out_stall,
    input  logic                  wb_valid,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] vel_out,
    output logic                  vel_out_valid,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  busy,
    output logic                  done,
    output logic                  wb_overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_overflow;
    logic                  r_vel_valid;

    logic [ADDR_WIDTH-1:0] w_cnt_raw;
    logic [ADDR_WIDTH-1:0] w_cnt;
    logic                  w_rd_left;
    logic                  w_wr_ok;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_wb_drop;

    assign w_cnt_raw = mem_q[ADDR_WIDTH-1:0];
    assign w_cnt     = (w_cnt_raw > MAX_CNT) ? MAX_CNT : w_cnt_raw;

    assign w_rd_left = (r_rd_ptr <= r_count);
    // A write-back is only accepted while a particle is still owed one.
    assign w_wr_ok   = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && (r_wr_ptr <= r_count);
    assign w_wr_en   = wb_valid && w_wr_ok;
    // Write-back has priority on the single RAM port; the read simply slips a cycle.
    assign w_rd_en   = (r_state == S_STREAM) && !w_wr_en && !out_stall && w_rd_left;
    assign w_wb_drop = wb_valid && !w_wr_ok;

    always_comb begin
        mem_address = '0;
        if (w_wr_en) begin
            mem_address = r_wr_ptr;
        end else if (w_rd_en) begin
            mem_address = r_rd_ptr;
        end
    end

    assign mem_data       = w_wr_en ? wb_data : '0;
    assign mem_wren       = w_wr_en;
    assign mem_rden       = (r_state == S_RD_CNT) || w_rd_en;
    assign vel_out_valid  = r_vel_valid;
    assign vel_out        = r_vel_valid ? mem_q : '0;
    assign particle_count = r_count;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign wb_overflow    = r_overflow;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_RD_CNT;
            S_RD_CNT:   w_next = S_WAIT_CNT;
            S_WAIT_CNT: w_next = (w_cnt == '0) ? S_DONE : S_STREAM;
            S_STREAM: begin
                if (w_wr_en && (r_wr_ptr == r_count)) begin
                    w_next = S_DONE;
                end else if ((w_rd_en && (r_rd_ptr == r_count)) || !w_rd_left) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN:    if (w_wr_en && (r_wr_ptr == r_count)) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_vel_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_vel_valid <= w_rd_en;
            if (r_state == S_WAIT_CNT) begin
                r_count  <= w_cnt;
                r_rd_ptr <= 1;
                r_wr_ptr <= 1;
            end else begin
                if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // A dropped write-back in the same cycle as start still counts as an error.
            if ((r_state == S_IDLE) && start) r_overflow <= 1'b0;
            if (w_wb_drop) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_velocity_cell_ctrl.sv
// tb/tb_velocity_cell_ctrl.sv - scoreboard bench for velocity_cell_ctrl
module tb_velocity_cell_ctrl;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;
    localparam logic [DW-1:0] KEY = {32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_stall;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] mem_q;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] vel_out;
    logic          vel_out_valid;
    logic [AW-1:0] particle_count;
    logic          busy;
    logic          done;
    logic          wb_overflow;

    always #5 clk = ~clk;

    velocity_cell_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .out_stall(out_stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .mem_q(mem_q),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .vel_out(vel_out), .vel_out_valid(vel_out_valid),
        .particle_count(particle_count), .busy(busy), .done(done),
        .wb_overflow(wb_overflow)
    );

    // Cell RAM model with a preload port for the bench.
    logic [DW-1:0] ram [0:255];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard queues.
    int            q_rd[$];
    logic [DW-1:0] q_vel[$];
    int            q_wa[$];
    logic [DW-1:0] q_wd[$];
    logic [DW-1:0] mq_d[$];
    int            mq_t[$];
    int            lat = 2;
    int            n_done = 0;
    int            done_cyc = 0;
    int            rd0_cyc = 0;
    int            last_wr_cyc = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_rden || mem_wren) check("rd_wr_exclusive", DW'(mem_rden & mem_wren), '0);
            if (out_stall && mem_rden) check("rd_in_stall", DW'(mem_address), '0);
            if (mem_rden) begin
                if (mem_address == '0) rd0_cyc = cyc;
                if (q_rd.size() == 0) check("rd_unexpected", DW'(mem_address), '1);
                else check("rd_addr", DW'(mem_address), DW'(q_rd.pop_front()));
            end
            if (mem_wren) begin
                last_wr_cyc = cyc;
                if (q_wa.size() == 0) check("wr_unexpected", DW'(mem_address), '1);
                else begin
                    check("wr_addr", DW'(mem_address), DW'(q_wa.pop_front()));
                    check("wr_data", mem_data, q_wd.pop_front());
                end
            end
            if (vel_out_valid) begin
                if (q_vel.size() == 0) check("vel_unexpected", vel_out, ~vel_out);
                else check("vel_out", vel_out, q_vel.pop_front());
                mq_d.push_back(vel_out ^ KEY);
                mq_t.push_back(cyc + lat);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Motion-update unit model: returns each velocity lat cycles after it appears.
    logic          resp_wb = 1'b0;
    logic          man_wb = 1'b0;
    logic [DW-1:0] resp_data = '0;
    always @(posedge clk) begin
        #1;
        if (mq_t.size() > 0 && mq_t[0] <= cyc) begin
            resp_wb   = 1'b1;
            resp_data = mq_d.pop_front();
            void'(mq_t.pop_front());
        end else begin
            resp_wb   = 1'b0;
            resp_data = '0;
        end
    end
    assign wb_valid = resp_wb | man_wb;
    assign wb_data  = resp_data;

    logic [DW-1:0] img [0:255];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input int cnt_word);
        img[0] = DW'(cnt_word);
        for (int i = 1; i <= n; i++) img[i] = {$urandom, $urandom, $urandom};
        for (int i = 0; i <= n; i++) begin
            pl_we   = 1'b1;
            pl_addr = AW'(i);
            pl_data = img[i];
            tick(1);
        end
        pl_we = 1'b0;
    endtask

    task automatic expect_pass(input int n);
        q_rd.push_back(0);
        for (int i = 1; i <= n; i++) begin
            q_rd.push_back(i);
            q_vel.push_back(img[i]);
            q_wa.push_back(i);
            q_wd.push_back(img[i] ^ KEY);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic finish_pass(input string tag, input int n, input int budget);
        int d0;
        int k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_done_seen"}, DW'(n_done - d0), DW'(1));
        check({tag, "_busy_after"}, DW'(busy), '0);
        check({tag, "_count"}, DW'(particle_count), DW'(n));
        check({tag, "_sb_empty"}, DW'(q_rd.size() + q_vel.size() + q_wa.size() + q_wd.size()), '0);
        check({tag, "_no_overflow"}, DW'(wb_overflow), '0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, DW'(mem_address), '0);
        check({tag, "_mdata"}, mem_data, '0);
        check({tag, "_rden"}, DW'(mem_rden), '0);
        check({tag, "_wren"}, DW'(mem_wren), '0);
        check({tag, "_vel"}, vel_out, '0);
        check({tag, "_velv"}, DW'(vel_out_valid), '0);
        check({tag, "_count"}, DW'(particle_count), '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
        check({tag, "_ovf"}, DW'(wb_overflow), '0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_stall = 1'b0;
        tick(2);
        rst = 1'b0;
        check_zero("reset");

        // Count 3, write-back two cycles after each velocity.
        lat = 2;
        preload(3, 3);
        expect_pass(3);
        pulse_start();
        finish_pass("cnt3", 3, 200);
        check("cnt3_done_after_wr", DW'(done_cyc - last_wr_cyc), DW'(1));

        // Empty cell.
        preload(0, 0);
        expect_pass(0);
        pulse_start();
        finish_pass("cnt0", 0, 50);
        check("cnt0_done_lat", DW'(done_cyc - rd0_cyc), DW'(2));

        // Write-backs land on cycles where a read is due.
        lat = 1;
        preload(4, 4);
        expect_pass(4);
        pulse_start();
        finish_pass("cnt4_collide", 4, 200);

        // Five-cycle stall after the first particle read.
        lat = 2;
        preload(2, 2);
        expect_pass(2);
        pulse_start();
        tick(3);
        out_stall = 1'b1;
        tick(5);
        out_stall = 1'b0;
        finish_pass("cnt2_stall", 2, 200);

        // Count word beyond the cell depth is clamped.
        preload(PN - 1, 255);
        expect_pass(PN - 1);
        pulse_start();
        finish_pass("clamp", PN - 1, 3000);

        // Reset in the middle of streaming, then a fresh pass.
        preload(3, 3);
        expect_pass(3);
        pulse_start();
        tick(4);
        check("mid_stream_busy", DW'(busy), DW'(1));
        rst = 1'b1;
        q_rd.delete(); q_vel.delete(); q_wa.delete(); q_wd.delete();
        mq_d.delete(); mq_t.delete();
        tick(1);
        rst = 1'b0;
        check_zero("mid_rst");
        man_wb = 1'b1;
        tick(1);
        man_wb = 1'b0;
        check("idle_wb_overflow", DW'(wb_overflow), DW'(1));
        preload(3, 3);
        check("overflow_sticky", DW'(wb_overflow), DW'(1));
        expect_pass(3);
        pulse_start();
        check("overflow_cleared", DW'(wb_overflow), '0);
        finish_pass("restart", 3, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/velocity_cell_ctrl.md
VELOCITY_CELL_CTRL -- requirements
Module: velocity_cell_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, velocity word width {vz, vy, vx}, 32 bits each.
REQ-002 SHALL have parameter PARTICLE_NUM, default 220, cell RAM depth including count word at address 0.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a cell update pass.
REQ-007 out_stall  input  1  motion-update unit cannot accept a new velocity next cycle.
REQ-008 wb_valid  input  1  updated velocity present on wb_data.
REQ-009 wb_data  input  DATA_WIDTH  updated velocity, returned in particle order.
REQ-010 mem_q  input  DATA_WIDTH  RAM read data, valid 1 cycle after a read.
REQ-011 mem_address  output  ADDR_WIDTH  RAM address.
REQ-012 mem_data  output  DATA_WIDTH  RAM write data.
REQ-013 mem_rden / mem_wren  output  1 each  RAM read and write enables.
REQ-014 vel_out  output  DATA_WIDTH  velocity to motion-update unit; vel_out_valid  output  1  qualifies it.
REQ-015 particle_count  output  ADDR_WIDTH  count latched from address 0.
REQ-016 busy  output  1; done  output  1 (one-cycle pulse); wb_overflow  output  1 (sticky error).

Function
REQ-017 SHALL implement states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE.
REQ-018 IDLE: start=1 -> RD_CNT, clear wb_overflow; start in any other state SHALL be ignored.
REQ-019 RD_CNT: mem_address=0, mem_rden=1 for one cycle -> WAIT_CNT.
REQ-020 WAIT_CNT: latch particle_count = mem_q[ADDR_WIDTH-1:0], clamped to PARTICLE_NUM-1; rd_ptr=wr_ptr=1; count 0 -> DONE, else -> STREAM.
REQ-021 mem_rden and mem_wren SHALL never both be 1 in one cycle (single-port RAM).
REQ-022 STREAM, per cycle, priority: wb_valid=1 -> write wb_data at wr_ptr (mem_wren=1), wr_ptr++; else if out_stall=0 and rd_ptr<=particle_count -> read rd_ptr (mem_rden=1), rd_ptr++; else idle cycle.
REQ-023 vel_out_valid SHALL be 1 exactly one cycle after each STREAM read, vel_out=mem_q that cycle; 0 otherwise.
REQ-024 STREAM -> DRAIN once rd_ptr exceeds particle_count; DRAIN performs writes only.
REQ-025 When the write at wr_ptr==particle_count completes (STREAM or DRAIN) -> DONE.
REQ-026 DONE: done=1 one cycle -> IDLE.
REQ-027 wb_valid in IDLE, RD_CNT, WAIT_CNT, DONE, or after all writes taken SHALL be dropped and set wb_overflow until next start or rst.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Read address SHALL always exceed or equal pending write address; no read of a particle before its own write-back is not required (writes trail reads).
REQ-030 Pointers SHALL be ADDR_WIDTH bits; no wrap-around occurs since particle_count<=PARTICLE_NUM-1.

Reset
REQ-031 rst=1 SHALL, at any state including mid-pass, force IDLE next cycle and zero mem_address, mem_data, mem_rden, mem_wren, vel_out, vel_out_valid, particle_count, busy, done, wb_overflow, rd_ptr, wr_ptr.
REQ-032 An interrupted pass SHALL not resume; RAM contents are left as partially written.

Verification
REQ-033 Count=3, out_stall=0, each wb_valid 2 cycles after vel_out_valid -> reads addr 1,2,3, writes addr 1,2,3, done 1 cycle after last write, never rden&wren together.
REQ-034 Count=0 at address 0 -> no particle reads/writes, done pulses 2 cycles after RD_CNT, busy drops next cycle.
REQ-035 Count=4, wb_valid held 1 in the cycle a read is due -> write wins, read of that address delayed one cycle, vel_out order unchanged.
REQ-036 Count=2, out_stall=1 for 5 cycles mid-stream -> no mem_rden during stall, resumes at next address, no duplicate or missing vel_out.
REQ-037 Count=255 in RAM, PARTICLE_NUM=220 -> particle_count=219, last read address 219.
REQ-038 rst mid-STREAM, then start -> all outputs 0 after rst, new pass re-reads address 0; wb_valid during IDLE sets wb_overflow, cleared by start.
